// File: rtl/dmem_pkg.sv
// Shared encodings for the MEM-stage data memory:
// access sizes, clear-sequencer states and the alignment rule.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } dmem_state_t;

    function automatic logic size_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        unique case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction and sign/zero extension, plus
// the size/offset legality check shared by loads and stores.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_bsign;
    logic        w_hsign;

    always_comb begin
        unique case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    assign w_half  = i_offset[1] ? i_word[31:16] : i_word[15:0];
    assign w_bsign = ~i_unsigned & w_byte[7];
    assign w_hsign = ~i_unsigned & w_half[15];

    assign o_misaligned = size_misaligned(i_size, i_offset);

    // Illegal shapes return zero so the top never leaks a torn value.
    always_comb begin
        o_data = '0;
        if (!o_misaligned) begin
            unique case (i_size)
                SZ_BYTE: o_data = {{24{w_bsign}}, w_byte};
                SZ_HALF: o_data = {{16{w_hsign}}, w_half};
                SZ_WORD: o_data = i_word;
                default: o_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// MEM-stage data memory: byte-lane store merge, extended loads,
// optional registered read and a post-reset clear sequencer.
module data_memory_bytelane
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter bit READ_REG       = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH+1:0] i_address,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_mem_write_data,
    output logic [31:0]           o_mem_read_data,
    output logic                  o_read_valid,
    output logic                  o_misaligned,
    output logic                  o_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    logic [31:0]           r_mem [DEPTH];
    dmem_state_t           r_state;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [1:0]            w_off;
    logic                  w_req;
    logic                  w_bad;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rd_word;
    logic [31:0]           w_ext;

    assign w_idx     = i_address[ADDR_WIDTH+1:2];
    assign w_off     = i_address[1:0];
    assign w_req     = i_mem_read | i_mem_write;
    assign w_wr_en   = i_mem_write & ~r_busy & ~w_bad;
    assign w_rd_en   = i_mem_read & ~r_busy & ~w_bad;
    assign w_rd_word = r_mem[w_idx];

    assign o_misaligned = w_req & w_bad;
    assign o_busy       = r_busy;

    // Store data is replicated so every enabled lane sees its bytes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_mem_write_data;
        unique case (i_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{i_mem_write_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_mem_write_data[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_READY;
            end
            r_busy    <= CLEAR_ON_RESET;
            r_clr_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_IDX) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    dmem_load_align u_align (
        .i_word       (w_rd_word),
        .i_offset     (w_off),
        .i_size       (i_size),
        .i_unsigned   (i_unsigned),
        .o_data       (w_ext),
        .o_misaligned (w_bad)
    );

    generate
        if (READ_REG) begin : g_rd_reg
            logic [31:0] r_rdata;
            logic        r_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_en;
                    if (w_rd_en) begin
                        r_rdata <= w_ext;
                    end
                end
            end

            assign o_mem_read_data = r_rdata;
            assign o_read_valid    = r_valid;
        end else begin : g_rd_comb
            assign o_mem_read_data = w_rd_en ? w_ext : '0;
            assign o_read_valid    = w_rd_en;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed bench: combinational, registered and no-clear
// variants share one stimulus stream.
module tb_data_memory_bytelane;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  addr;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] wdata;

    logic [31:0] rdata0, rdata1, rdata2;
    logic        rv0, rv1, rv2;
    logic        mis0, mis1, mis2;
    logic        busy0, busy1, busy2;

    int n_cmp;
    int n_err;
    int n;

    localparam int NEXT = 8;
    logic [5:0]  ext_a [NEXT] = '{6'h01, 6'h02, 6'h02, 6'h02,
                                  6'h02, 6'h03, 6'h00, 6'h00};
    logic [1:0]  ext_s [NEXT] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF,
                                  SZ_HALF, SZ_BYTE, SZ_HALF, SZ_WORD};
    logic        ext_u [NEXT] = '{1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ext_e [NEXT] = '{32'h0000007F, 32'hFFFFFFFF,
                                  32'h000000FF, 32'hFFFF80FF,
                                  32'h000080FF, 32'hFFFFFF80,
                                  32'h00007F01, 32'h80FF7F01};

    always #5 clk = ~clk;

    data_memory_bytelane #(
        .ADDR_WIDTH(4), .READ_REG(1'b0), .CLEAR_ON_RESET(1'b1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .i_address(addr),
        .i_mem_read(rd), .i_mem_write(wr), .i_size(sz),
        .i_unsigned(uns), .i_mem_write_data(wdata),
        .o_mem_read_data(rdata0), .o_read_valid(rv0),
        .o_misaligned(mis0), .o_busy(busy0)
    );

    data_memory_bytelane #(
        .ADDR_WIDTH(4), .READ_REG(1'b1), .CLEAR_ON_RESET(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .i_address(addr),
        .i_mem_read(rd), .i_mem_write(wr), .i_size(sz),
        .i_unsigned(uns), .i_mem_write_data(wdata),
        .o_mem_read_data(rdata1), .o_read_valid(rv1),
        .o_misaligned(mis1), .o_busy(busy1)
    );

    data_memory_bytelane #(
        .ADDR_WIDTH(4), .READ_REG(1'b0), .CLEAR_ON_RESET(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .i_address(addr),
        .i_mem_read(rd), .i_mem_write(wr), .i_size(sz),
        .i_unsigned(uns), .i_mem_write_data(wdata),
        .o_mem_read_data(rdata2), .o_read_valid(rv2),
        .o_misaligned(mis2), .o_busy(busy2)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag,
                        input logic obs,
                        input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b",
                   tag, obs, exp);
        end
    endtask

    task automatic req(input logic r, input logic w,
                       input logic [1:0] s, input logic u,
                       input logic [5:0] a, input logic [31:0] d);
        rd    = r;
        wr    = w;
        sz    = s;
        uns   = u;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, SZ_BYTE, 1'b0, 6'h00, 32'h0);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        step();
        step();
        chk1("rst_busy0", busy0, 1'b1);
        chk1("rst_busy2", busy2, 1'b0);
        chk1("rst_valid1", rv1, 1'b0);
        chk("rst_data1", rdata1, 32'h0);

        step();
        rst_n = 1'b1;
        #1;
        n = 0;
        for (int k = 0; k < 100 && busy0; k++) begin
            n++;
            step();
        end
        chk("clr_cycles", 32'(n), 32'd16);
        chk1("clr_busy1", busy1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            req(1'b0, 1'b1, SZ_WORD, 1'b0, {i[3:0], 2'b00},
                32'hDEAD0000 | 32'(i));
            step();
        end
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h14, 32'h0);
        #1;
        chk("garbage_w5", rdata0, 32'hDEAD0005);

        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (7) step();
        chk1("pre_abort_busy", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("abort_busy", busy0, 1'b1);
        chk1("abort_rv1", rv1, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        n = 0;
        for (int k = 0; k < 100 && busy0; k++) begin
            n++;
            if (k == 5) begin
                req(1'b1, 1'b1, SZ_WORD, 1'b0, 6'h04, 32'h55);
                #1;
                chk1("busy_rv0", rv0, 1'b0);
            end else if (k == 8) begin
                req(1'b0, 1'b1, SZ_HALF, 1'b0, 6'h05, 32'hFFFF);
                #1;
                chk1("busy_mis0", mis0, 1'b1);
            end else begin
                idle();
            end
            step();
            if (k == 5) chk1("busy_rv1", rv1, 1'b0);
        end
        chk("clr2_cycles", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            req(1'b1, 1'b0, SZ_WORD, 1'b0, {i[3:0], 2'b00}, 32'h0);
            #1;
            chk("clr_word0", rdata0, 32'h0);
            step();
            chk("clr_word1", rdata1, 32'h0);
            chk1("clr_rv1", rv1, 1'b1);
        end

        req(1'b0, 1'b1, SZ_WORD, 1'b0, 6'h08, 32'h11223344);
        step();
        req(1'b0, 1'b1, SZ_BYTE, 1'b0, 6'h09, 32'h5A5A5AAA);
        step();
        req(1'b0, 1'b1, SZ_HALF, 1'b0, 6'h0A, 32'h1234BEEF);
        step();
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h08, 32'h0);
        #1;
        chk("lane_lw0", rdata0, 32'hBEEFAA44);
        chk1("lane_rv0", rv0, 1'b1);
        step();
        chk("lane_lw1", rdata1, 32'hBEEFAA44);

        req(1'b0, 1'b1, SZ_WORD, 1'b0, 6'h00, 32'h80FF7F01);
        step();
        for (int i = 0; i < NEXT; i++) begin
            req(1'b1, 1'b0, ext_s[i], ext_u[i], ext_a[i], 32'h0);
            #1;
            chk("ext0", rdata0, ext_e[i]);
            step();
            chk("ext1", rdata1, ext_e[i]);
            chk1("ext_rv1", rv1, 1'b1);
        end

        req(1'b0, 1'b1, SZ_HALF, 1'b0, 6'h05, 32'hFFFF);
        #1;
        chk1("mis_sh", mis0, 1'b1);
        step();
        req(1'b0, 1'b1, SZ_WORD, 1'b0, 6'h06, 32'hFFFFFFFF);
        #1;
        chk1("mis_sw", mis0, 1'b1);
        step();
        req(1'b0, 1'b1, 2'b11, 1'b0, 6'h04, 32'hFFFFFFFF);
        #1;
        chk1("mis_sz3", mis0, 1'b1);
        step();
        req(1'b0, 1'b0, 2'b11, 1'b0, 6'h06, 32'h0);
        #1;
        chk1("mis_noreq", mis0, 1'b0);
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h04, 32'h0);
        #1;
        chk1("mis_legal", mis0, 1'b0);
        chk("mis_keep0", rdata0, 32'h0);
        chk("mis_keep2", rdata2, 32'h00000055);
        step();
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h02, 32'h0);
        #1;
        chk1("mis_lw", mis0, 1'b1);
        chk1("mis_lw_rv0", rv0, 1'b0);
        chk("mis_lw_d0", rdata0, 32'h0);
        step();
        chk1("mis_lw_rv1", rv1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            req(1'b0, 1'b1, SZ_WORD, 1'b0, 6'(6'h30 + 4 * i),
                32'(i + 1));
            step();
        end
        chk1("rr_idle_rv1", rv1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, SZ_WORD, 1'b0, 6'(6'h30 + 4 * i),
                32'h0);
            step();
            chk1("rr_rv1", rv1, 1'b1);
            chk("rr_d1", rdata1, 32'(i + 1));
        end
        idle();
        step();
        chk1("rr_pulse", rv1, 1'b0);
        chk("rr_hold", rdata1, 32'h3);

        req(1'b1, 1'b1, SZ_WORD, 1'b0, 6'h30, 32'd9);
        #1;
        chk("raw_old0", rdata0, 32'h1);
        step();
        chk("raw_old1", rdata1, 32'h1);
        req(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h30, 32'h0);
        #1;
        chk("raw_new0", rdata0, 32'd9);
        step();
        chk("raw_new1", rdata1, 32'd9);

        req(1'b1, 1'b0, SZ_WORD, 1'b0, 6'h0C, 32'h0);
        #1;
        chk("noclr_w3_0", rdata0, 32'h0);
        chk("noclr_w3_2", rdata2, 32'hDEAD0003);
        chk1("noclr_busy2", busy2, 1'b0);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
